// File: rtl/fp_convert_arbiter.sv
// -----------------------------------------------------------------------------
// fp_convert_arbiter
//
// Shares one fixed-latency float conversion unit among NUM_REQ requesters.
// Requests are granted round-robin, one per cycle. Each issue is tracked by a
// {valid, tag} pipe that runs alongside the unit. Results are captured into a
// DEPTH-entry FIFO. A credit counter stops issue before that FIFO can overflow,
// so stalling the result port never loses a result.
//
// Build option:
//   FPCA_FIXED_PRIORITY_EN - when defined, the lowest-indexed valid requester
//                            always wins and no round-robin pointer exists.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_data       packed request words, requester i at [i*IN_W +: IN_W]
//   req_ready      one-hot accept back to the requesters
//   pu_in_valid    issue strobe to the shared unit
//   pu_in_data     word issued to the shared unit (0 when idle)
//   pu_out_data    shared unit result, PIPE_LAT cycles after issue
//   res_valid      result FIFO not empty
//   res_ready      consumer accept
//   res_data       head result word
//   res_tag        requester index owning the head result
//   busy           at least one accepted word not yet consumed
// -----------------------------------------------------------------------------
module fp_convert_arbiter #(
    parameter int MANTISSA_LEN = 23,
    parameter int IN_W         = 32,
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LAT     = 3,
    localparam int FP_W        = MANTISSA_LEN + 9,
    localparam int TAG_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int DEPTH       = PIPE_LAT + 2,
    localparam int CNT_W       = $clog2(DEPTH + 1),
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    pu_in_valid,
    output logic [IN_W-1:0]         pu_in_data,
    input  logic [FP_W-1:0]         pu_out_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FP_W-1:0]         res_data,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    busy
);

    // FIFO pointer increment with wrap at DEPTH (DEPTH need not be a power of 2)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
    endfunction

    logic [TAG_W-1:0] grant_s;
    logic             found_s;
    logic             issue_s;
    logic             pop_s;
    logic             push_s;

    logic [CNT_W-1:0] outstanding_r;
    logic             tag_vld_r [PIPE_LAT];
    logic [TAG_W-1:0] tag_r     [PIPE_LAT];
    logic [FP_W-1:0]  fifo_data_r [DEPTH];
    logic [TAG_W-1:0] fifo_tag_r  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

`ifdef FPCA_FIXED_PRIORITY_EN
    // Grant selection: lowest-indexed valid requester wins
    always_comb begin
        grant_s = {TAG_W{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_s = (!found_s && req_valid[k]) ? TAG_W'(k) : grant_s;
            found_s = found_s | req_valid[k];
        end
    end
`else
    logic [TAG_W-1:0] rr_ptr_r;

    // Grant selection: first valid requester at or above rr_ptr_r, wrapping
    always_comb begin
        logic [TAG_W:0] cand;
        grant_s = {TAG_W{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // one extra bit so the sum cannot alias before the explicit wrap
            cand    = {1'b0, rr_ptr_r} + (TAG_W+1)'(k);
            cand    = (cand >= (TAG_W+1)'(NUM_REQ)) ? cand - (TAG_W+1)'(NUM_REQ) : cand;
            grant_s = (!found_s && req_valid[cand[TAG_W-1:0]]) ? cand[TAG_W-1:0] : grant_s;
            found_s = found_s | req_valid[cand[TAG_W-1:0]];
        end
    end

    // Round-robin pointer: moves past the winner on every issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {TAG_W{1'b0}};
        end else if (issue_s) begin
            rr_ptr_r <= (grant_s == TAG_W'(NUM_REQ - 1)) ? {TAG_W{1'b0}} : grant_s + TAG_W'(1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Issue only while a FIFO slot is guaranteed for the result
    assign issue_s     = (|req_valid) & (outstanding_r < CNT_W'(DEPTH));
    assign req_ready   = {NUM_REQ{issue_s}} & (NUM_REQ'(1'b1) << grant_s);
    assign pu_in_valid = issue_s;
    assign pu_in_data  = issue_s ? req_data[grant_s*IN_W +: IN_W] : {IN_W{1'b0}};

    assign pop_s  = res_valid & res_ready;
    assign push_s = tag_vld_r[PIPE_LAT-1];

    // Credit counter: words accepted but not yet taken by the consumer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({issue_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Tag pipe: shifts every cycle, mirroring the unit's fixed latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_vld_r[i] <= 1'b0;
                tag_r[i]     <= {TAG_W{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= issue_s;
            tag_r[0]     <= grant_s;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_r[i]     <= tag_r[i-1];
            end
        end
    end

    // Result FIFO: capture from the unit, pop on consumer handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_r[i] <= {FP_W{1'b0}};
                fifo_tag_r[i]  <= {TAG_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= pu_out_data;
                fifo_tag_r[wr_ptr_r]  <= tag_r[PIPE_LAT-1];
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            // a push into an empty FIFO becomes visible only on the next cycle
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Outputs are taken directly from state registers
    assign res_valid = (count_r != {CNT_W{1'b0}});
    assign res_data  = fifo_data_r[rd_ptr_r];
    assign res_tag   = fifo_tag_r[rd_ptr_r];
    assign busy      = (outstanding_r != {CNT_W{1'b0}});

endmodule
